sram_rr_arbiter: RTL and testbench
==================================

// Module: sram_rr_arbiter
// PURPOSE
// - Shares one single-port sram instance (1 rd/wr per cycle, fixed read latency) between NumReq requesters.
// - Round-robin grant, forwarding of the granted request to the SRAM, and routing of responses
//   back to the issuing requester after exactly Latency cycles.
// - Sits between core/DMA-side memory ports and the L1/L2 SRAM cut; no buffering of requests.
// PARAMETERS
// - NumReq     4     number of requesters (>=2)
// - DataWidth  64    data width [bit], multiple of 8
// - NumWords   1024  SRAM depth; AddrWidth = $clog2(NumWords)
// - Latency    1     SRAM read latency [cycles] (>=1); must equal the attached sram LATENCY
// PORTS
// - clk_i         in   1                   clock
// - rst_i         in   1                   synchronous reset, active-high
// - req_i         in   NumReq              per-requester request valid
// - we_i          in   NumReq              per-requester write enable
// - addr_i        in   NumReq*AddrWidth    per-requester word address (requester k at slice k)
// - wdata_i       in   NumReq*DataWidth    per-requester write data
// - be_i          in   NumReq*DataWidth/8  per-requester byte enables
// - gnt_o         out  NumReq              one-hot grant; request accepted when req_i[k]&gnt_o[k]
// - rvalid_o      out  NumReq              one-hot response valid (reads and writes)
// - rdata_o       out  DataWidth           response data, shared; valid for reads when rvalid_o[k]
// - sram_req_o    out  1                   to sram req_i
// - sram_we_o     out  1                   to sram we_i
// - sram_addr_o   out  AddrWidth           to sram addr_i
// - sram_wdata_o  out  DataWidth           to sram wdata_i
// - sram_be_o     out  DataWidth/8         to sram be_i
// - sram_rdata_i  in   DataWidth           from sram rdata_o
// BEHAVIOUR
// - Arbitration combinational, same cycle: gnt_o = first set bit of req_i searching upward (with
//   wrap) from index prio_q. At most one gnt_o bit set; gnt_o=0 when req_i=0. Never grant without req.
// - prio_q (clog2(NumReq) bits) register: on a grant to k, prio_q <= (k+1) mod NumReq;
//   unchanged with no grant. Reset value 0 -> requester 0 has priority first.
// - SRAM side: sram_req_o = |gnt_o; we/addr/wdata/be muxed from the granted requester;
//   all sram_* outputs driven 0 when no grant.
// - Requesters must hold req/we/addr/wdata/be stable until granted; may drop req after grant.
// - Response pipeline: Latency-stage shift register of {valid, id, we}. Stage 0 loaded on grant.
//   rvalid_o[id] asserted exactly Latency cycles after the grant cycle, for reads and writes.
// - rdata_o = sram_rdata_i when the emerging entry is a read; 0 otherwise (writes, idle).
// - Back-to-back grants every cycle sustained; responses return in grant order, one per cycle max.
// - Requests are not cancellable; there is no backpressure on responses (requester always accepts).
// - Reset (sync, any cycle): prio_q<=0, all pipeline valid bits <=0. gnt_o is combinational but
//   forced 0 while rst_i=1; rvalid_o=0, sram_req_o=0. In-flight responses are dropped.
// - Outputs after reset: gnt_o=0 until req, rvalid_o=0, rdata_o=0, sram_* = 0.
// - Assertions: $onehot0(gnt_o), $onehot0(rvalid_o), gnt_o subset of req_i.
// TESTING
// - Single read: req_i=4'b0100, addr=0x10 (preloaded 0xDEAD_BEEF) -> gnt_o=0100 same cycle;
//   rvalid_o=0100, rdata_o=0xDEADBEEF Latency cycles later.
// - Contention: req_i=4'b1111 held 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3;
//   one rvalid per cycle in that order.
// - Fairness w/ gaps: req_i=4'b1001 continuous -> grants alternate 0,3,0,3; requester 1,2 never granted.
// - Write-then-read: req 2 writes 0xCAFE to addr 5 be=all-ones, then req 1 reads addr 5 ->
//   write ack rvalid_o[2] with rdata_o=0; read returns 0xCAFE on rvalid_o[1].
// - Byte enables: write 0xFFFF.. to addr 7 then 0x00.. with be=0x01 -> readback 0x..FF00.
// - Reset mid-flight: Latency=2, grant read at cycle t, rst_i=1 at t+1 -> no rvalid at t+2;
//   prio_q=0 after reset (req_i=1111 -> first grant to 0).

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters.
// Grants are combinational; responses return to the issuer exactly Latency cycles later.

module sram_rr_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 64,
  parameter int NumWords  = 1024,
  parameter int Latency   = 1,
  localparam int AddrWidth = $clog2(NumWords),
  localparam int BeWidth   = DataWidth / 8,
  localparam int IdWidth   = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*BeWidth-1:0]     be_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [AddrWidth-1:0]          sram_addr_o,
  output logic [DataWidth-1:0]          sram_wdata_o,
  output logic [BeWidth-1:0]            sram_be_o,
  input  logic [DataWidth-1:0]          sram_rdata_i
);

  logic [IdWidth-1:0]              prio_q, prio_d;
  logic [NumReq-1:0]               gnt_s;
  logic [IdWidth-1:0]              gnt_id_s;
  logic                            gnt_any_s;
  logic [IdWidth:0]                scan_idx_s;
  logic [Latency-1:0]              vld_q, vld_d;
  logic [Latency-1:0]              rsp_we_q, rsp_we_d;
  logic [Latency-1:0][IdWidth-1:0] rsp_id_q, rsp_id_d;

  function automatic logic [IdWidth-1:0] wrap_inc(input logic [IdWidth-1:0] v);
    if (int'(v) == NumReq - 1) begin
      return '0;
    end else begin
      return v + IdWidth'(1);
    end
  endfunction

  // Scan upward from prio_q with wrap; the first requesting index wins.
  always_comb begin
    gnt_s      = '0;
    gnt_id_s   = '0;
    gnt_any_s  = 1'b0;
    scan_idx_s = '0;
    if (!rst_i) begin
      for (int i = 0; i < NumReq; i++) begin
        scan_idx_s = {1'b0, prio_q} + (IdWidth+1)'(i);
        if (scan_idx_s >= (IdWidth+1)'(NumReq)) begin
          scan_idx_s = scan_idx_s - (IdWidth+1)'(NumReq);
        end else begin
          scan_idx_s = scan_idx_s;
        end
        if (!gnt_any_s && req_i[scan_idx_s[IdWidth-1:0]]) begin
          gnt_any_s = 1'b1;
          gnt_id_s  = scan_idx_s[IdWidth-1:0];
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
      if (gnt_any_s) begin
        gnt_s[gnt_id_s] = 1'b1;
      end else begin
        gnt_s = '0;
      end
    end else begin
      gnt_s = '0;
    end
  end

  assign gnt_o = gnt_s;

  // Priority rotates to the index just after the winner.
  always_comb begin
    prio_d = prio_q;
    if (gnt_any_s) begin
      prio_d = wrap_inc(gnt_id_s);
    end else begin
      prio_d = prio_q;
    end
  end

  // Forward the granted request to the SRAM; everything is zero when idle.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (gnt_any_s) begin
      sram_req_o   = 1'b1;
      sram_we_o    = we_i[gnt_id_s];
      sram_addr_o  = addr_i[int'(gnt_id_s)*AddrWidth +: AddrWidth];
      sram_wdata_o = wdata_i[int'(gnt_id_s)*DataWidth +: DataWidth];
      sram_be_o    = be_i[int'(gnt_id_s)*BeWidth +: BeWidth];
    end else begin
      sram_req_o   = 1'b0;
    end
  end

  // Response tag pipeline: stage 0 captures the grant, the last stage emerges.
  always_comb begin
    vld_d       = vld_q;
    rsp_we_d    = rsp_we_q;
    rsp_id_d    = rsp_id_q;
    vld_d[0]    = gnt_any_s;
    rsp_we_d[0] = gnt_any_s & we_i[gnt_id_s];
    rsp_id_d[0] = gnt_id_s;
    for (int s = 1; s < Latency; s++) begin
      vld_d[s]    = vld_q[s-1];
      rsp_we_d[s] = rsp_we_q[s-1];
      rsp_id_d[s] = rsp_id_q[s-1];
    end
  end

  // State registers with synchronous reset; in-flight responses are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q   <= '0;
      vld_q    <= '0;
      rsp_we_q <= '0;
      rsp_id_q <= '0;
    end else begin
      prio_q   <= prio_d;
      vld_q    <= vld_d;
      rsp_we_q <= rsp_we_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  // Route the emerging response; write acks carry zero data.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (!rst_i && vld_q[Latency-1]) begin
      rvalid_o[rsp_id_q[Latency-1]] = 1'b1;
      if (!rsp_we_q[Latency-1]) begin
        rdata_o = sram_rdata_i;
      end else begin
        rdata_o = '0;
      end
    end else begin
      rvalid_o = '0;
    end
  end

  sram_rr_arbiter_chk #(.NumReq(NumReq)) u_chk (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .gnt_i    (gnt_s),
    .rvalid_i (rvalid_o)
  );

endmodule

// Protocol properties of the arbiter outputs.
module sram_rr_arbiter_chk #(
  parameter int NumReq = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic [NumReq-1:0] req_i,
  input logic [NumReq-1:0] gnt_i,
  input logic [NumReq-1:0] rvalid_i
);

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_i));
  a_rvalid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rvalid_i));
  a_gnt_needs_req : assert property (@(posedge clk_i) disable iff (rst_i) ((gnt_i & ~req_i) == '0));

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: SRAM model, per-cycle queue-based reference model,
// arbitration vector table, directed corner sequences and randomized traffic.

module tb_sram_rr_arbiter;

  localparam int NumReq    = 4;
  localparam int DataWidth = 64;
  localparam int NumWords  = 1024;
  localparam int Latency   = 2;
  localparam int AddrWidth = 10;
  localparam int BeWidth   = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NumReq-1:0]           req, we, gnt, rvalid;
  logic [NumReq*AddrWidth-1:0] addr;
  logic [NumReq*DataWidth-1:0] wdata;
  logic [NumReq*BeWidth-1:0]   be;
  logic [DataWidth-1:0]        rdata, sram_wdata, sram_rdata;
  logic                        sram_req, sram_we;
  logic [AddrWidth-1:0]        sram_addr;
  logic [BeWidth-1:0]          sram_be;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.NumReq(NumReq), .DataWidth(DataWidth), .NumWords(NumWords), .Latency(Latency)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  // Contents of a never-written word.
  function automatic logic [63:0] init_word(input logic [9:0] a);
    if (a == 10'h010) return 64'h0000_0000_DEAD_BEEF;
    return {32'(a) * 32'h9E37_79B9, 22'h0, a};
  endfunction

  // SRAM model: byte-enabled writes, reads visible Latency cycles after the request.
  logic [63:0] mem [NumWords];
  bit          mem_wr [NumWords];
  logic [63:0] rd_pipe [Latency];
  always @(posedge clk) begin
    if (sram_req && sram_we) begin
      for (int b = 0; b < BeWidth; b++)
        mem[sram_addr][b*8 +: 8] <= sram_be[b] ? sram_wdata[b*8 +: 8]
                                   : (mem_wr[sram_addr] ? mem[sram_addr][b*8 +: 8] : init_word(sram_addr) >> (b*8));
      mem_wr[sram_addr] <= 1'b1;
    end
    if (sram_req && !sram_we) rd_pipe[0] <= mem_wr[sram_addr] ? mem[sram_addr] : init_word(sram_addr);
    for (int s = 1; s < Latency; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign sram_rdata = rd_pipe[Latency-1];

  // Reference model state (written only from the main process).
  typedef struct { int due; int id; bit rd; logic [63:0] data; } resp_t;
  resp_t       rq[$];
  logic [63:0] ref_mem [NumWords];
  bit          ref_wr [NumWords];
  int          prio = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct { logic [3:0] req; logic [3:0] gnt; } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input logic [9:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  // Per-cycle reference: round-robin pick by arithmetic, responses from a due-time queue.
  task automatic model_check();
    logic [3:0]  eg, erv;
    logic [63:0] erd, ewd, nw;
    logic [9:0]  ea;
    logic [7:0]  ebe;
    logic        ewe;
    int          g, k;
    cyc++;
    erv = '0; erd = '0; eg = '0; ea = '0; ewd = '0; ebe = '0; ewe = 1'b0; g = -1;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      erv[rq[0].id] = 1'b1;
      erd = rq[0].rd ? rq[0].data : 64'h0;
      void'(rq.pop_front());
    end
    if (rst) begin
      rq.delete();
      prio = 0; erv = '0; erd = '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        k = (prio + i) % NumReq;
        if (g < 0 && req[k]) g = k;
      end
    end
    if (g >= 0) begin
      eg[g] = 1'b1;
      ewe = we[g];
      ea  = addr[g*AddrWidth +: AddrWidth];
      ewd = wdata[g*DataWidth +: DataWidth];
      ebe = be[g*BeWidth +: BeWidth];
      if (ewe) begin
        nw = ref_word(ea);
        for (int b = 0; b < BeWidth; b++) if (ebe[b]) nw[b*8 +: 8] = ewd[b*8 +: 8];
        ref_mem[ea] = nw;
        ref_wr[ea]  = 1'b1;
        rq.push_back('{cyc + Latency, g, 1'b0, 64'h0});
      end else begin
        rq.push_back('{cyc + Latency, g, 1'b1, ref_word(ea)});
      end
      prio = (g + 1) % NumReq;
    end
    check("m_gnt", 64'(gnt), 64'(eg));
    check("m_sram_req", 64'(sram_req), 64'(g >= 0));
    check("m_sram_we", 64'(sram_we), 64'(ewe));
    check("m_sram_addr", 64'(sram_addr), 64'(ea));
    check("m_sram_wdata", sram_wdata, ewd);
    check("m_sram_be", 64'(sram_be), 64'(ebe));
    check("m_rvalid", 64'(rvalid), 64'(erv));
    check("m_rdata", rdata, erd);
  endtask

  task automatic idle();
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic put(input int k, input logic w, input logic [9:0] a, input logic [63:0] d, input logic [7:0] b);
    req[k] = 1'b1; we[k] = w;
    addr[k*AddrWidth +: AddrWidth] = a;
    wdata[k*DataWidth +: DataWidth] = d;
    be[k*BeWidth +: BeWidth] = b;
  endtask

  task automatic cyc_begin();
    @(posedge clk); #1;
  endtask

  task automatic cyc_end();
    @(negedge clk);
    model_check();
  endtask

  bit          pend [NumReq];
  logic        pw [NumReq];
  logic [9:0]  pa [NumReq];
  logic [63:0] pd [NumReq];
  logic [7:0]  pb [NumReq];

  initial begin
    // Hand-derived round-robin sequence from prio=0; unserved requesters keep requesting.
    tbl[0]  = '{4'b0100, 4'b0100}; tbl[1]  = '{4'b0111, 4'b0001};
    tbl[2]  = '{4'b0110, 4'b0010}; tbl[3]  = '{4'b1100, 4'b0100};
    tbl[4]  = '{4'b1001, 4'b1000}; tbl[5]  = '{4'b1011, 4'b0001};
    tbl[6]  = '{4'b1010, 4'b0010}; tbl[7]  = '{4'b1000, 4'b1000};
    tbl[8]  = '{4'b0000, 4'b0000}; tbl[9]  = '{4'b1110, 4'b0010};
    tbl[10] = '{4'b1100, 4'b0100}; tbl[11] = '{4'b1101, 4'b1000};
    tbl[12] = '{4'b0101, 4'b0001}; tbl[13] = '{4'b0100, 4'b0100};
    tbl[14] = '{4'b0000, 4'b0000}; tbl[15] = '{4'b0000, 4'b0000};

    rst = 1'b1;
    idle();
    repeat (3) begin cyc_begin(); cyc_end(); end
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_sram_req", 64'(sram_req), 64'h0);

    // Arbitration table.
    for (int i = 0; i < 16; i++) begin
      cyc_begin(); rst = 1'b0; idle();
      for (int k = 0; k < NumReq; k++) if (tbl[i].req[k]) put(k, 1'b0, 10'(k*3 + 1), 64'h0, 8'h00);
      cyc_end();
      check("tbl_gnt", 64'(gnt), 64'(tbl[i].gnt));
      check("tbl_rvalid", 64'(rvalid), (i >= Latency) ? 64'(tbl[i-Latency].gnt) : 64'h0);
    end

    // Single read of preloaded word.
    cyc_begin(); idle(); put(2, 1'b0, 10'h010, 64'h0, 8'h00); cyc_end();
    check("rd_gnt", 64'(gnt), 64'h4);
    cyc_begin(); idle(); cyc_end();
    check("rd_early", 64'(rvalid), 64'h0);
    cyc_begin(); cyc_end();
    check("rd_rvalid", 64'(rvalid), 64'h4);
    check("rd_rdata", rdata, 64'h0000_0000_DEAD_BEEF);

    // Write by 2, then read back by 1.
    cyc_begin(); idle(); put(2, 1'b1, 10'd5, 64'hCAFE, 8'hFF); cyc_end();
    check("wr_gnt", 64'(gnt), 64'h4);
    cyc_begin(); idle(); put(1, 1'b0, 10'd5, 64'h0, 8'h00); cyc_end();
    check("wr_rd_gnt", 64'(gnt), 64'h2);
    cyc_begin(); idle(); cyc_end();
    check("wr_ack", 64'(rvalid), 64'h4);
    check("wr_ack_data", rdata, 64'h0);
    cyc_begin(); cyc_end();
    check("wr_rd_rvalid", 64'(rvalid), 64'h2);
    check("wr_rd_rdata", rdata, 64'hCAFE);

    // Byte-enable merge.
    cyc_begin(); idle(); put(0, 1'b1, 10'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); cyc_end();
    cyc_begin(); idle(); put(0, 1'b1, 10'd7, 64'h0, 8'h01); cyc_end();
    cyc_begin(); idle(); put(0, 1'b0, 10'd7, 64'h0, 8'h00); cyc_end();
    check("be_ack", 64'(rvalid), 64'h1);
    cyc_begin(); idle(); cyc_end();
    cyc_begin(); cyc_end();
    check("be_rvalid", 64'(rvalid), 64'h1);
    check("be_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF00);

    // Full contention straight after reset.
    cyc_begin(); idle(); rst = 1'b1; cyc_end();
    for (int i = 0; i < 8 + Latency; i++) begin
      cyc_begin(); rst = 1'b0; idle();
      if (i < 8) for (int k = 0; k < NumReq; k++) put(k, 1'b0, 10'(k + 32), 64'h0, 8'h00);
      cyc_end();
      check("cont_gnt", 64'(gnt), (i < 8) ? (64'h1 << (i % 4)) : 64'h0);
      check("cont_rvalid", 64'(rvalid), (i >= Latency) ? (64'h1 << ((i - Latency) % 4)) : 64'h0);
    end

    // Fairness with gaps.
    for (int i = 0; i < 6; i++) begin
      cyc_begin(); idle();
      put(0, 1'b0, 10'd40, 64'h0, 8'h00); put(3, 1'b0, 10'd43, 64'h0, 8'h00);
      cyc_end();
      check("fair_gnt", 64'(gnt), (i % 2 == 0) ? 64'h1 : 64'h8);
    end
    cyc_begin(); idle(); cyc_end();
    cyc_begin(); cyc_end();

    // Reset while a read is in flight.
    cyc_begin(); idle(); put(1, 1'b0, 10'd3, 64'h0, 8'h00); cyc_end();
    check("mid_gnt", 64'(gnt), 64'h2);
    cyc_begin(); idle(); rst = 1'b1; cyc_end();
    check("mid_rst_rvalid", 64'(rvalid), 64'h0);
    cyc_begin(); rst = 1'b0; cyc_end();
    check("mid_drop", 64'(rvalid), 64'h0);
    for (int j = 0; j < NumReq; j++) begin
      cyc_begin(); idle();
      for (int k = j; k < NumReq; k++) put(k, 1'b0, 10'(k + 50), 64'h0, 8'h00);
      cyc_end();
      check("mid_prio_gnt", 64'(gnt), 64'h1 << j);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < NumReq; k++) pend[k] = 1'b0;
    for (int n = 0; n < 500; n++) begin
      cyc_begin();
      rst = ($urandom_range(0, 199) == 0);
      idle();
      for (int k = 0; k < NumReq; k++) begin
        if (!pend[k] && $urandom_range(0, 99) < 55) begin
          pend[k] = 1'b1;
          pw[k] = 1'($urandom_range(0, 1));
          pa[k] = 10'($urandom_range(0, 31));
          pd[k] = {$urandom, $urandom};
          pb[k] = 8'($urandom);
        end
        if (pend[k]) put(k, pw[k], pa[k], pd[k], pb[k]);
      end
      cyc_end();
      for (int k = 0; k < NumReq; k++) if (gnt[k]) pend[k] = 1'b0;
    end
    cyc_begin(); rst = 1'b0; idle(); cyc_end();
    repeat (Latency + 2) begin cyc_begin(); cyc_end(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
